// File: rtl/dmem_port_ctrl_pkg.sv
// Shared types and default widths for the data-SRAM port controller.
package dmem_pkg;
  localparam int DMEM_ADDR_W     = 16;
  localparam int DMEM_DATA_W     = 16;
  localparam int DMEM_WBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_READ  = 2'd1,
    P_WRITE = 2'd2
  } port_state_e;

  typedef enum logic [1:0] {
    FWD_SRAM  = 2'd0,
    FWD_STORE = 2'd1,
    FWD_BUF   = 2'd2
  } fwd_src_e;
endpackage

// File: rtl/dmem_port_ctrl_if.sv
// CPU-side handshake bundle: stage-3 operand reads and stage-5 stores.
interface dmem_cpu_if #(
  parameter int AW = dmem_pkg::DMEM_ADDR_W,
  parameter int DW = dmem_pkg::DMEM_DATA_W
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          wbuf_empty;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ready, rd_valid, rd_data, wr_ready, wbuf_empty
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ready, rd_valid, rd_data, wr_ready, wbuf_empty
  );
endinterface

// File: rtl/dmem_port_ctrl_wbuf.sv
// Store FIFO with youngest-first address match for read forwarding.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter  int AW    = DMEM_ADDR_W,
  parameter  int DW    = DMEM_DATA_W,
  parameter  int DEPTH = DMEM_WBUF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic [AW-1:0] rd_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q, idx;
  logic [CW-1:0]            count_q;
  logic                     bypass, wr_en;
  fwd_src_e                 src;
  logic [DW-1:0]            buf_data;

  // An empty buffer hands a same-cycle store straight to the port.
  assign bypass    = (count_q == '0);
  assign wr_en     = push & ~(pop & bypass);
  assign head_addr = bypass ? push_addr : addr_q[rd_ptr_q];
  assign head_data = bypass ? push_data : data_q[rd_ptr_q];
  assign count     = count_q;

  // Scan oldest to youngest so the last match wins; the incoming store beats all.
  always_comb begin
    src      = FWD_SRAM;
    buf_data = '0;
    idx      = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == rd_addr)) begin
        src      = FWD_BUF;
        buf_data = data_q[idx];
      end
    end
    if (push && (push_addr == rd_addr)) src = FWD_STORE;
  end

  assign hit      = (src != FWD_SRAM);
  assign hit_data = (src == FWD_STORE) ? push_data : buf_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en)          wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !bypass) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/dmem_port_ctrl.sv
// Single-port data-SRAM controller: read/store arbitration, write buffer, fixed 2-cycle reads.
module dmem_port_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int WBUF_DEPTH = DMEM_WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_cpu_if.slave             cpu,
  output logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  we_n
);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  logic [CW-1:0]         count;
  logic                  full, wr_acc, rd_acc, rd_miss, pop, hit;
  logic [DATA_WIDTH-1:0] hit_data, head_data;
  logic [ADDR_WIDTH-1:0] head_addr;
  port_state_e           state_q, state_d;
  logic [1:0]            vld_pipe_q;
  logic                  hit_pipe_q, we_n_q;
  logic [DATA_WIDTH-1:0] fwd_q, rd_data_q, data_out_q;
  logic [ADDR_WIDTH-1:0] addr_1_q;

  assign full     = (count == CW'(WBUF_DEPTH));
  assign wr_acc   = cpu.wr_req & ~full;
  assign rd_acc   = cpu.rd_req & (hit | ~full);
  assign rd_miss  = rd_acc & ~hit;

  assign cpu.wr_ready   = ~full;
  assign cpu.rd_ready   = hit | ~full;
  assign cpu.rd_valid   = vld_pipe_q[1];
  assign cpu.rd_data    = rd_data_q;
  assign cpu.wbuf_empty = (count == '0) & (state_q != P_WRITE);

  // A miss read owns the port; otherwise any pending store drains.
  always_comb begin
    state_d = P_IDLE;
    if (rd_miss)                       state_d = P_READ;
    else if ((count != '0) || wr_acc)  state_d = P_WRITE;
  end

  assign pop = (state_d == P_WRITE);

  dmem_wbuf #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_acc),
    .push_addr (cpu.wr_addr),
    .push_data (cpu.wr_data),
    .pop       (pop),
    .rd_addr   (cpu.rd_addr),
    .hit       (hit),
    .hit_data  (hit_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= P_IDLE;
      we_n_q     <= 1'b1;
      addr_1_q   <= '0;
      data_out_q <= '0;
      vld_pipe_q <= '0;
      hit_pipe_q <= 1'b0;
      fwd_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_n_q  <= (state_d != P_WRITE);
      if (state_d == P_READ) begin
        addr_1_q <= cpu.rd_addr;
      end else if (state_d == P_WRITE) begin
        addr_1_q   <= head_addr;
        data_out_q <= head_data;
      end
      vld_pipe_q <= {vld_pipe_q[0], rd_acc};
      hit_pipe_q <= hit;
      fwd_q      <= hit_data;
      // Hits and misses both land in the second response stage.
      if (vld_pipe_q[0]) rd_data_q <= hit_pipe_q ? fwd_q : data_in;
    end
  end

  assign addr_1   = addr_1_q;
  assign data_out = data_out_q;
  assign we_n     = we_n_q;
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: directed vector table, reset corner case, random traffic vs a memory model.
module tb_dmem_port_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_1, data_in, data_out;
  logic        we_n;

  dmem_cpu_if #(.AW(16), .DW(16)) cpu();

  dmem_port_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WBUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .cpu(cpu),
    .addr_1(addr_1), .data_in(data_in), .data_out(data_out), .we_n(we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] iv(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : {a[7:0], ~a[7:0]};
  endfunction

  // Behavioural SRAM: combinational read, write on posedge when we_n is low.
  logic [15:0] ram [256];
  bit          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= iv(16'(i));
      ram_init <= 1'b1;
    end else if (we_n === 1'b0) begin
      ram[addr_1[7:0]] <= data_out;
    end
  end
  assign data_in = ram[addr_1[7:0]];

  typedef struct { logic [15:0] data; int due; } rexp_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } st_t;
  typedef struct {
    logic        rr; logic [15:0] ra; logic wr; logic [15:0] wa; logic [15:0] wd;
    logic        e_rrdy, e_wrdy, e_wen, e_empty, e_vld; logic [15:0] e_data;
    logic        ca; logic [15:0] e_addr;
  } vec_t;

  int          checks = 0, errors = 0, cyc = 0, n = 0, mism = 0;
  bit          done;
  logic [15:0] ref_mem [256];   // program-order view of memory
  logic [15:0] sram_ref [256];  // what should physically be in SRAM
  rexp_t       rq[$];
  st_t         sq[$];
  vec_t        tbl [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    bit exp_now;
    cyc++;
    exp_now = (rq.size() > 0) && (rq[0].due == cyc);
    if (exp_now || cpu.rd_valid === 1'b1) begin
      chk("rd_valid_timing", 32'(cpu.rd_valid), 32'(exp_now));
      if (exp_now) begin
        if (cpu.rd_valid === 1'b1) chk("rd_data_model", 32'(cpu.rd_data), 32'(rq[0].data));
        void'(rq.pop_front());
      end
    end
    if (we_n === 1'b0) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sram_write_spurious cyc=%0d actual addr=%h data=%h expected no write", cyc, addr_1, data_out);
      end else begin
        chk("sram_wr_addr", 32'(addr_1), 32'(sq[0].addr));
        chk("sram_wr_data", 32'(data_out), 32'(sq[0].data));
        sram_ref[sq[0].addr[7:0]] = sq[0].data;
        void'(sq.pop_front());
      end
    end
    if (reset) begin
      rq.delete();
      sq.delete();
      ref_mem = sram_ref;
    end else begin
      // A store accepted this cycle is newer than a read accepted this cycle.
      if (cpu.wr_req && cpu.wr_ready === 1'b1) begin
        ref_mem[cpu.wr_addr[7:0]] = cpu.wr_data;
        sq.push_back('{cpu.wr_addr, cpu.wr_data});
      end
      if (cpu.rd_req && cpu.rd_ready === 1'b1)
        rq.push_back('{ref_mem[cpu.rd_addr[7:0]], cyc + 2});
    end
  endtask

  task automatic drive(input logic rr, input logic [15:0] ra, input logic wr,
                       input logic [15:0] wa, input logic [15:0] wd);
    cpu.rd_req = rr; cpu.rd_addr = ra; cpu.wr_req = wr; cpu.wr_addr = wa; cpu.wr_data = wd;
  endtask

  task automatic sample();
    @(negedge clk); monitor();
  endtask

  task automatic cyc_end();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we_n"},       32'(we_n), 1);
    chk({tag, "_addr_1"},     32'(addr_1), 0);
    chk({tag, "_data_out"},   32'(data_out), 0);
    chk({tag, "_rd_valid"},   32'(cpu.rd_valid), 0);
    chk({tag, "_rd_data"},    32'(cpu.rd_data), 0);
    chk({tag, "_rd_ready"},   32'(cpu.rd_ready), 1);
    chk({tag, "_wr_ready"},   32'(cpu.wr_ready), 1);
    chk({tag, "_wbuf_empty"}, 32'(cpu.wbuf_empty), 1);
  endtask

  function automatic vec_t v(input logic rr, input logic [15:0] ra, input logic wr,
                             input logic [15:0] wa, input logic [15:0] wd,
                             input logic rrdy, input logic wrdy, input logic wen, input logic emp,
                             input logic vld, input logic [15:0] dat, input logic ca, input logic [15:0] ea);
    vec_t t;
    t.rr = rr; t.ra = ra; t.wr = wr; t.wa = wa; t.wd = wd;
    t.e_rrdy = rrdy; t.e_wrdy = wrdy; t.e_wen = wen; t.e_empty = emp;
    t.e_vld = vld; t.e_data = dat; t.ca = ca; t.e_addr = ea;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = iv(16'(i));
      sram_ref[i] = iv(16'(i));
    end
    //            rr ra      wr wa      wd        rrdy wrdy wen emp vld data         ca addr
    tbl[0]  = v(1, 16'h010, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);
    tbl[1]  = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 0, 16'h0000,     1, 16'h010);
    tbl[2]  = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 1, 16'h1234,     0, 16'h000);
    tbl[3]  = v(1, 16'h020, 1, 16'h020, 16'hBEEF, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);
    tbl[4]  = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 0, 0, 0, 16'h0000,     1, 16'h020);
    tbl[5]  = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 1, 16'hBEEF,     0, 16'h000);
    tbl[6]  = v(1, 16'h020, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);
    tbl[7]  = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 0, 16'h0000,     1, 16'h020);
    tbl[8]  = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 1, 16'hBEEF,     0, 16'h000);
    tbl[9]  = v(1, 16'h040, 1, 16'h030, 16'h0001, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);
    tbl[10] = v(1, 16'h041, 1, 16'h030, 16'h0002, 1, 1, 1, 0, 0, 16'h0000,     1, 16'h040);
    tbl[11] = v(1, 16'h030, 0, 16'h000, 16'h0000, 1, 0, 1, 0, 1, iv(16'h040), 1, 16'h041);
    tbl[12] = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 0, 0, 1, iv(16'h041), 1, 16'h030);
    tbl[13] = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 0, 0, 1, 16'h0002,     1, 16'h030);
    tbl[14] = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);
    tbl[15] = v(1, 16'h060, 1, 16'h050, 16'h1111, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);
    tbl[16] = v(1, 16'h061, 1, 16'h051, 16'h2222, 1, 1, 1, 0, 0, 16'h0000,     1, 16'h060);
    tbl[17] = v(1, 16'h062, 1, 16'h052, 16'h3333, 0, 0, 1, 0, 1, iv(16'h060), 1, 16'h061);
    tbl[18] = v(1, 16'h062, 1, 16'h052, 16'h3333, 1, 1, 0, 0, 1, iv(16'h061), 1, 16'h050);
    tbl[19] = v(1, 16'h063, 0, 16'h000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000,     1, 16'h062);
    tbl[20] = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 0, 0, 1, iv(16'h062), 1, 16'h051);
    tbl[21] = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 0, 0, 0, 16'h0000,     1, 16'h052);
    tbl[22] = v(0, 16'h000, 0, 16'h000, 16'h0000, 1, 1, 1, 1, 0, 16'h0000,     0, 16'h000);

    // Power-on reset.
    drive(0, 0, 0, 0, 0);
    cyc_end();
    sample(); chk_reset("por"); cyc_end();
    reset = 1'b0;
    repeat (2) begin sample(); cyc_end(); end

    // Directed vectors: forwarding, drain timing, full-buffer stall.
    for (int k = 0; k < 23; k++) begin
      drive(tbl[k].rr, tbl[k].ra, tbl[k].wr, tbl[k].wa, tbl[k].wd);
      sample();
      chk($sformatf("t%0d_rd_ready", k),   32'(cpu.rd_ready),   32'(tbl[k].e_rrdy));
      chk($sformatf("t%0d_wr_ready", k),   32'(cpu.wr_ready),   32'(tbl[k].e_wrdy));
      chk($sformatf("t%0d_we_n", k),       32'(we_n),           32'(tbl[k].e_wen));
      chk($sformatf("t%0d_wbuf_empty", k), 32'(cpu.wbuf_empty), 32'(tbl[k].e_empty));
      chk($sformatf("t%0d_rd_valid", k),   32'(cpu.rd_valid),   32'(tbl[k].e_vld));
      if (tbl[k].e_vld) chk($sformatf("t%0d_rd_data", k), 32'(cpu.rd_data), 32'(tbl[k].e_data));
      if (tbl[k].ca)    chk($sformatf("t%0d_addr_1", k),  32'(addr_1),      32'(tbl[k].e_addr));
      cyc_end();
    end
    chk("stores_landed_030", 32'(ram[8'h30]), 32'h0002);
    chk("stores_landed_052", 32'(ram[8'h52]), 32'h3333);

    // Reset with one store buffered, a store request live and a read in flight.
    drive(1, 16'h071, 1, 16'h070, 16'h7777);
    sample(); chk("pre_reset_buffered", 32'(cpu.wr_ready), 1); cyc_end();
    reset = 1'b1;
    drive(1, 16'h073, 1, 16'h072, 16'h8888);
    sample(); cyc_end();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    sample(); chk_reset("mid_reset"); cyc_end();
    repeat (4) begin sample(); cyc_end(); end
    chk("discarded_store_070", 32'(ram[8'h70]), 32'(iv(16'h070)));
    chk("discarded_store_072", 32'(ram[8'h72]), 32'(iv(16'h072)));

    // Random interleaved traffic on a small address window to provoke hits.
    for (int k = 0; k < 150; k++) begin
      drive($urandom_range(0, 9) < 6, 16'h080 + 16'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 16'h080 + 16'($urandom_range(0, 7)), 16'($urandom));
      sample(); cyc_end();
    end

    drive(0, 0, 0, 0, 0);
    done = 1'b0;
    n = 0;
    while (n < 30 && !done) begin
      sample();
      done = (cpu.wbuf_empty === 1'b1) && (rq.size() == 0) && (sq.size() == 0);
      cyc_end();
      n++;
    end
    chk("drain_within_bound", 32'(done), 1);

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("final_sram_image_mismatches", 32'(mism), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
